// File: rtl/split_mul_sequencer_pkg.sv
// Shared types and constants for the split-mantissa multiply sequencer.
package split_mul_sequencer_pkg;

  localparam int unsigned LoWDefault = 16;
  localparam int unsigned HiWDefault = 15;

  // Signed two's-complement product of the two 31-bit magnitudes.
  typedef logic [63:0] product_t;

  typedef enum logic [2:0] {
    StIdle,
    StMulLl,
    StMulHl,
    StMulLh,
    StMulHh,
    StDone
  } state_t;

endpackage

// File: rtl/mul16u.sv
// Combinational 16x16 unsigned multiplier shared by all partial products.
module mul16u (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  // Full-width unsigned product.
  always_comb begin
    p = 32'(a) * 32'(b);
  end

endmodule

// File: rtl/split_mul_sequencer.sv
// Sign-magnitude multiplier: four 16x16 partial products through one shared
// multiplier, accumulated over four cycles, then sign-applied into a 64-bit result.
module split_mul_sequencer
  import split_mul_sequencer_pkg::*;
#(
  parameter int unsigned LO_W = LoWDefault,
  parameter int unsigned HI_W = HiWDefault
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [HI_W-1:0] a_hi,
  input  logic [LO_W-1:0] a_lo,
  input  logic            sign_a,
  input  logic [HI_W-1:0] b_hi,
  input  logic [LO_W-1:0] b_lo,
  input  logic            sign_b,
  input  logic            clear,
  output logic            out_valid,
  input  logic            out_ready,
  output product_t        product
);

  state_t          state_q, state_d;
  logic [HI_W-1:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d;
  logic [LO_W-1:0] a_lo_q, a_lo_d, b_lo_q, b_lo_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  product_t        acc_q, acc_d;
  product_t        product_q, product_d;

  logic [15:0]     mul_a, mul_b;
  logic [31:0]     mul_p;
  product_t        pp_shifted;
  product_t        acc_sum;

  // Operand mux: pick which halves feed the shared multiplier this cycle.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StMulLl: begin
        mul_a = 16'(a_lo_q);
        mul_b = 16'(b_lo_q);
      end
      StMulHl: begin
        mul_a = 16'(a_hi_q);
        mul_b = 16'(b_lo_q);
      end
      StMulLh: begin
        mul_a = 16'(a_lo_q);
        mul_b = 16'(b_hi_q);
      end
      StMulHh: begin
        mul_a = 16'(a_hi_q);
        mul_b = 16'(b_hi_q);
      end
      default: ;
    endcase
  end

  mul16u u_mul16u (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Align the partial product to its weight and add it to the running sum.
  always_comb begin
    pp_shifted = '0;
    case (state_q)
      StMulLl:          pp_shifted = product_t'(mul_p);
      StMulHl, StMulLh: pp_shifted = product_t'(mul_p) << 16;
      StMulHh:          pp_shifted = product_t'(mul_p) << 32;
      default: ;
    endcase
    acc_sum = acc_q + pp_shifted;
  end

  // Next-state and datapath updates; clear overrides everything, including a handshake.
  always_comb begin
    state_d   = state_q;
    a_hi_d    = a_hi_q;
    a_lo_d    = a_lo_q;
    b_hi_d    = b_hi_q;
    b_lo_d    = b_lo_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    acc_d     = acc_q;
    product_d = product_q;

    if (clear) begin
      state_d   = StIdle;
      product_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_hi_d   = a_hi;
            a_lo_d   = a_lo;
            b_hi_d   = b_hi;
            b_lo_d   = b_lo;
            sign_a_d = sign_a;
            sign_b_d = sign_b;
            acc_d    = '0;
            state_d  = StMulLl;
          end
        end
        StMulLl: begin
          acc_d   = acc_sum;
          state_d = StMulHl;
        end
        StMulHl: begin
          acc_d   = acc_sum;
          state_d = StMulLh;
        end
        StMulLh: begin
          acc_d   = acc_sum;
          state_d = StMulHh;
        end
        StMulHh: begin
          acc_d = acc_sum;
          // Negating a zero sum yields zero, so no negative zero can appear.
          product_d = (sign_a_q ^ sign_b_q) ? (product_t'(0) - acc_sum) : acc_sum;
          state_d   = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_hi_q    <= '0;
      a_lo_q    <= '0;
      b_hi_q    <= '0;
      b_lo_q    <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_hi_q    <= a_hi_d;
      a_lo_q    <= a_lo_d;
      b_hi_q    <= b_hi_d;
      b_lo_q    <= b_lo_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  // Handshake outputs decode directly from state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    product   = product_q;
  end

endmodule
